trdb_packet_arbiter: RTL

Parametrised, registered successor to the trace packet priority encoder. It latches packet-generation requests from `NREQ` channels into a pending mask and serves them in fixed priority order, with channel 0 highest. Each served request becomes a packet format/subformat descriptor on a valid/ready output. It also adds a programmable periodic resync request and sticky overflow detection. It sits between the trace qualification/branch-map logic and the packet emitter.

---
 rtl/trdb_packet_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/trdb_packet_arbiter.sv
// Registered fixed-priority trace packet arbiter: latches per-channel packet requests,
// serves them lowest-index first as format/subformat descriptors, adds periodic resync.
module trdb_packet_arbiter #(
  parameter int unsigned NREQ     = 8,
  parameter int unsigned RESYNC_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [2*NREQ-1:0]     req_format_i,
  input  logic [2*NREQ-1:0]     req_subformat_i,
  input  logic [NREQ-1:0]       req_dynfmt_i,
  input  logic                  branch_map_empty_i,
  input  logic [RESYNC_W-1:0]   resync_max_i,
  input  logic                  clr_overflow_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [1:0]            packet_format_o,
  output logic [1:0]            packet_subformat_o,
  output logic [NREQ:0]         grant_o,
  output logic                  overflow_o,
  output logic [7:0]            drop_cnt_o
);

  typedef enum logic [1:0] {
    F_BRANCH_FULL = 2'd0,
    F_BRANCH_DIFF = 2'd1,
    F_ADDR_ONLY   = 2'd2,
    F_SYNC        = 2'd3
  } trdb_format_t;

  typedef enum logic [1:0] {
    SF_START     = 2'd0,
    SF_EXCEPTION = 2'd1,
    SF_CONTEXT   = 2'd2,
    SF_UNDEF     = 2'd3
  } trdb_subformat_t;

  logic [NREQ:0]         in_vec;
  logic [NREQ:0]         pending_q;
  logic [NREQ:0]         cand;
  logic [NREQ:0]         grant;
  logic [RESYNC_W-1:0]   rcnt_q;
  logic [RESYNC_W-1:0]   rmax_m1;
  logic                  resync_fire;
  logic                  load;
  logic                  coalesce;
  logic                  sync_done;
  logic                  found;
  logic [1:0]            fmt_d;
  logic [1:0]            sf_d;

  assign rmax_m1     = resync_max_i - RESYNC_W'(1);
  assign resync_fire = (resync_max_i != '0) && valid_i && (rcnt_q == rmax_m1);
  assign in_vec      = {resync_fire, req_i & {NREQ{valid_i}}};
  assign cand        = pending_q | in_vec;
  assign load        = !valid_o || ready_i;
  assign sync_done   = valid_o && ready_i && (packet_format_o == F_SYNC);
  // A request already pending and not leaving this cycle is merged and lost.
  assign coalesce    = |(in_vec & pending_q & ~grant);

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (load) begin
      for (int unsigned k = 0; k <= NREQ; k++) begin
        if (cand[k] && !found) begin
          grant[k] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    fmt_d = F_ADDR_ONLY;
    sf_d  = SF_UNDEF;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        if (req_dynfmt_i[k]) begin
          fmt_d = branch_map_empty_i ? F_ADDR_ONLY : F_BRANCH_FULL;
          sf_d  = SF_UNDEF;
        end else begin
          fmt_d = req_format_i[2*k +: 2];
          sf_d  = req_subformat_i[2*k +: 2];
        end
      end
    end
    if (grant[NREQ]) begin
      fmt_d = F_SYNC;
      sf_d  = SF_START;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o            <= 1'b0;
      packet_format_o    <= F_ADDR_ONLY;
      packet_subformat_o <= SF_UNDEF;
      grant_o            <= '0;
      pending_q          <= '0;
      rcnt_q             <= '0;
      overflow_o         <= 1'b0;
      drop_cnt_o         <= '0;
    end else begin
      pending_q <= cand & ~grant;

      if (load) begin
        valid_o <= |cand;
        if (|cand) begin
          grant_o            <= grant;
          packet_format_o    <= fmt_d;
          packet_subformat_o <= sf_d;
        end
      end

      // A completed sync packet restarts the period even if the counter would advance.
      if (sync_done || resync_fire) begin
        rcnt_q <= '0;
      end else if (valid_i) begin
        rcnt_q <= rcnt_q + RESYNC_W'(1);
      end

      if (clr_overflow_i) begin
        overflow_o <= 1'b0;
        drop_cnt_o <= '0;
      end else if (coalesce) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 8'hFF) begin
          drop_cnt_o <= drop_cnt_o + 8'd1;
        end
      end
    end
  end

endmodule
